// File: rtl/duck_hunt_pkg.sv
// Shared screen geometry, palette and bird FSM encoding for the duck hunt datapath.
package duck_hunt_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned SCAN_W   = 3;  // sprite dimensions up to 8 pixels

  localparam logic [COL_W-1:0] COL_BLACK  = 3'b000;
  localparam logic [COL_W-1:0] COL_YELLOW = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERASE  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_DRAW   = 3'd3,
    ST_KILL   = 3'd4
  } bird_state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  typedef struct packed {
    logic dy_neg;
    logic dx_neg;
  } dir_t;

  // States that emit one sprite pixel per cycle.
  function automatic logic is_scan(bird_state_e s);
    return (s == ST_ERASE) || (s == ST_KILL) || (s == ST_DRAW);
  endfunction

endpackage

// File: rtl/sprite_scanner.sv
// Row-major pixel offset counter over a w x h sprite; last flags the final offset.
module sprite_scanner
  import duck_hunt_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [SCAN_W:0]   w,
  input  logic [SCAN_W:0]   h,
  output logic [SCAN_W-1:0] cx,
  output logic [SCAN_W-1:0] cy,
  output logic              last
);

  logic [SCAN_W-1:0] cx_q, cx_d;
  logic [SCAN_W-1:0] cy_q, cy_d;
  logic [SCAN_W-1:0] w_last, h_last;
  logic              last_q, last_d;

  assign w_last = SCAN_W'(w - (SCAN_W+1)'(1));
  assign h_last = SCAN_W'(h - (SCAN_W+1)'(1));

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (start) begin
      cx_d = '0;
      cy_d = '0;
    end else if (cx_q == w_last) begin
      cx_d = '0;
      cy_d = (cy_q == h_last) ? '0 : cy_q + SCAN_W'(1);
    end else begin
      cx_d = cx_q + SCAN_W'(1);
    end
    last_d = (cx_d == w_last) && (cy_d == h_last);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx_q   <= '0;
      cy_q   <= '0;
      last_q <= 1'b0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      last_q <= last_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = last_q;

endmodule

// File: rtl/bird_renderer.sv
// Single bird sprite: per-frame erase/step/redraw pixel stream towards vga_adapter,
// with spawn, shot removal and dropped-tick reporting.
module bird_renderer
  import duck_hunt_pkg::*;
#(
  parameter int unsigned      BIRD_W   = 4,
  parameter int unsigned      BIRD_H   = 4,
  parameter logic [COL_W-1:0] BIRD_COL = COL_YELLOW,
  parameter logic [COL_W-1:0] BG_COL   = COL_BLACK
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             frame_tick,
  input  logic             spawn,
  input  logic [X_W-1:0]   spawn_x,
  input  logic [Y_W-1:0]   spawn_y,
  input  logic [1:0]       spawn_dir,
  input  logic             hit,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             alive,
  output logic             busy,
  output logic             overrun
);

  localparam logic [X_W-1:0]    XMAX    = X_W'(SCREEN_W - BIRD_W);
  localparam logic [Y_W-1:0]    YMAX    = Y_W'(SCREEN_H - BIRD_H);
  localparam logic [SCAN_W-1:0] ROW_END = SCAN_W'(BIRD_W - 1);

  bird_state_e       state_q, state_d;
  pos_t              pos_q, pos_d;
  dir_t              dir_q, dir_d;
  logic              alive_q, alive_d;
  logic              hit_pend_q, hit_pend_d;
  logic              tick_pend_q, tick_pend_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              plot_q, plot_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              scan_start, tick_taken, hit_now, scanning_d;
  logic [SCAN_W-1:0] cx, cy;
  logic              scan_last;

  sprite_scanner u_scan (
    .clock  (clock),
    .resetn (resetn),
    .start  (scan_start),
    .w      ((SCAN_W+1)'(BIRD_W)),
    .h      ((SCAN_W+1)'(BIRD_H)),
    .cx     (cx),
    .cy     (cy),
    .last   (scan_last)
  );

  // Next state, bird position/direction and pending-event flags.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    alive_d     = alive_q;
    hit_now     = hit_pend_q | (hit & alive_q);
    hit_pend_d  = hit_now;
    tick_pend_d = tick_pend_q;
    ovr_d       = 1'b0;
    scan_start  = 1'b0;
    tick_taken  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hit_now && alive_q) begin
          state_d    = ST_KILL;
          scan_start = 1'b1;
        end else if (spawn && !alive_q) begin
          pos_d.x    = (spawn_x > XMAX) ? XMAX : spawn_x;
          pos_d.y    = (spawn_y > YMAX) ? YMAX : spawn_y;
          dir_d      = dir_t'(spawn_dir);
          alive_d    = 1'b1;
          state_d    = ST_DRAW;
          scan_start = 1'b1;
        end else if ((frame_tick || tick_pend_q) && alive_q) begin
          state_d    = ST_ERASE;
          scan_start = 1'b1;
          tick_taken = 1'b1;
        end
      end
      ST_ERASE: begin
        if (scan_last) begin
          if (hit_now) begin
            alive_d    = 1'b0;
            hit_pend_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        // Bounce: at a wall the direction flips and the step goes the new way.
        if (dir_q.dx_neg) begin
          if (pos_q.x == '0) begin
            dir_d.dx_neg = 1'b0;
            pos_d.x      = pos_q.x + X_W'(1);
          end else begin
            pos_d.x = pos_q.x - X_W'(1);
          end
        end else if (pos_q.x == XMAX) begin
          dir_d.dx_neg = 1'b1;
          pos_d.x      = pos_q.x - X_W'(1);
        end else begin
          pos_d.x = pos_q.x + X_W'(1);
        end
        if (dir_q.dy_neg) begin
          if (pos_q.y == '0) begin
            dir_d.dy_neg = 1'b0;
            pos_d.y      = pos_q.y + Y_W'(1);
          end else begin
            pos_d.y = pos_q.y - Y_W'(1);
          end
        end else if (pos_q.y == YMAX) begin
          dir_d.dy_neg = 1'b1;
          pos_d.y      = pos_q.y - Y_W'(1);
        end else begin
          pos_d.y = pos_q.y + Y_W'(1);
        end
        state_d    = ST_DRAW;
        scan_start = 1'b1;
      end
      ST_DRAW: begin
        if (scan_last) state_d = ST_IDLE;
      end
      ST_KILL: begin
        if (scan_last) begin
          alive_d    = 1'b0;
          hit_pend_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // One tick may wait behind the current pass; a further one is dropped.
    if (tick_taken) begin
      tick_pend_d = frame_tick && tick_pend_q;
    end else if (frame_tick && alive_q) begin
      if (tick_pend_q) ovr_d = 1'b1;
      else             tick_pend_d = 1'b1;
    end
    if (!alive_d) tick_pend_d = 1'b0;
  end

  // Next pixel: sprite origin on scan entry, then row-major walk over the sprite.
  always_comb begin
    scanning_d = is_scan(state_d);
    plot_d     = scanning_d;
    busy_d     = (state_d != ST_IDLE);
    x_d        = '0;
    y_d        = '0;
    col_d      = '0;
    if (scan_start) begin
      x_d = pos_d.x;
      y_d = pos_d.y;
    end else if (scanning_d) begin
      if (cx == ROW_END) begin
        x_d = pos_q.x;
        y_d = pos_q.y + Y_W'(cy) + Y_W'(1);
      end else begin
        x_d = pos_q.x + X_W'(cx) + X_W'(1);
        y_d = pos_q.y + Y_W'(cy);
      end
    end
    if (scanning_d) col_d = (state_d == ST_DRAW) ? BIRD_COL : BG_COL;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      dir_q       <= '0;
      alive_q     <= 1'b0;
      hit_pend_q  <= 1'b0;
      tick_pend_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      alive_q     <= alive_d;
      hit_pend_q  <= hit_pend_d;
      tick_pend_q <= tick_pend_d;
      x_q         <= x_d;
      y_q         <= y_d;
      col_q       <= col_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
    end
  end

  assign x_out   = x_q;
  assign y_out   = y_q;
  assign colour  = col_q;
  assign plot    = plot_q;
  assign alive   = alive_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_bird_renderer.sv
// Directed bench for bird_renderer: spawn, move, bounce, clamp, tick queueing, hits, reset.
module tb_bird_renderer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       spawn = 1'b0;
  logic       hit = 1'b0;
  logic [7:0] spawn_x = '0;
  logic [6:0] spawn_y = '0;
  logic [1:0] spawn_dir = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, alive, busy, overrun;

  int checks = 0;
  int failures = 0;

  logic       cap_plot  [0:127];
  logic [7:0] cap_x     [0:127];
  logic [6:0] cap_y     [0:127];
  logic [2:0] cap_col   [0:127];
  logic       cap_busy  [0:127];
  logic       cap_alive [0:127];
  logic       cap_ovr   [0:127];

  bird_renderer dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .spawn      (spawn),
    .spawn_x    (spawn_x),
    .spawn_y    (spawn_y),
    .spawn_dir  (spawn_dir),
    .hit        (hit),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour     (colour),
    .plot       (plot),
    .alive      (alive),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic do_reset;
    resetn = 1'b0; frame_tick = 1'b0; spawn = 1'b0; hit = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_spawn(input logic [7:0] x, input logic [6:0] y, input logic [1:0] d);
    spawn_x = x; spawn_y = y; spawn_dir = d; spawn = 1'b1;
    @(negedge clock);
    spawn = 1'b0;
  endtask

  task automatic do_tick;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  // Record n cycles of outputs; optionally pulse tick (t1,t2) or hit (h) after sample i.
  task automatic capture(input int n, input int t1, input int t2, input int h);
    for (int i = 0; i < n; i++) begin
      cap_plot[i] = plot;  cap_x[i] = x_out;  cap_y[i] = y_out;  cap_col[i] = colour;
      cap_busy[i] = busy;  cap_alive[i] = alive;  cap_ovr[i] = overrun;
      frame_tick = (i == t1) || (i == t2);
      hit = (i == h);
      @(negedge clock);
    end
    frame_tick = 1'b0;
    hit = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({x_out, y_out, colour, plot, alive, busy, overrun} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs: got x=%0d y=%0d col=%0d plot=%0b alive=%0b busy=%0b ovr=%0b, want all 0",
               x_out, y_out, colour, plot, alive, busy, overrun);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_spawn_tick;
    int ex, ey;
    do_reset();
    do_spawn(8'd50, 7'd40, 2'b00);
    capture(17, -1, -1, -1);
    for (int k = 0; k < 16; k++) begin
      ex = 50 + k % 4; ey = 40 + k / 4;
      checks++;
      if ({cap_plot[k], cap_x[k], cap_y[k], cap_col[k]} !== {1'b1, 8'(ex), 7'(ey), 3'b110}) begin
        failures++;
        $display("FAIL spawn_draw[%0d]: got plot=%0b x=%0d y=%0d col=%0d, want 1 %0d %0d 6",
                 k, cap_plot[k], cap_x[k], cap_y[k], cap_col[k], ex, ey);
      end
    end
    checks++;
    if ({cap_plot[16], cap_busy[16], cap_alive[16]} !== 3'b001) begin
      failures++;
      $display("FAIL spawn_idle: got plot=%0b busy=%0b alive=%0b, want 0 0 1",
               cap_plot[16], cap_busy[16], cap_alive[16]);
    end
    do_tick();
    capture(34, -1, -1, -1);
    for (int i = 0; i < 34; i++) begin
      checks++;
      if (i < 16 || (i > 16 && i < 33)) begin
        ex = (i < 16) ? 50 + i % 4 : 51 + (i - 17) % 4;
        ey = (i < 16) ? 40 + i / 4 : 41 + (i - 17) / 4;
        if ({cap_plot[i], cap_busy[i], cap_x[i], cap_y[i], cap_col[i]} !==
            {2'b11, 8'(ex), 7'(ey), (i < 16) ? 3'b000 : 3'b110}) begin
          failures++;
          $display("FAIL pass1[%0d]: got plot=%0b busy=%0b x=%0d y=%0d col=%0d, want 1 1 %0d %0d %0d",
                   i, cap_plot[i], cap_busy[i], cap_x[i], cap_y[i], cap_col[i], ex, ey, (i < 16) ? 0 : 6);
        end
      end else if ({cap_plot[i], cap_busy[i]} !== {1'b0, i == 16}) begin
        failures++;
        $display("FAIL pass1_gap[%0d]: got plot=%0b busy=%0b, want plot=0 busy=%0b",
                 i, cap_plot[i], cap_busy[i], i == 16);
      end
    end
  endtask

  task automatic test_bounce;
    int ex, ey;
    do_reset();
    do_spawn(8'd156, 7'd116, 2'b00);
    capture(17, -1, -1, -1);
    for (int p = 0; p < 2; p++) begin
      do_tick();
      capture(34, -1, -1, -1);
      for (int k = 0; k < 16; k++) begin
        ex = 155 - p + k % 4; ey = 115 - p + k / 4;
        checks++;
        if ({cap_plot[17+k], cap_x[17+k], cap_y[17+k], cap_col[17+k]} !== {1'b1, 8'(ex), 7'(ey), 3'b110}) begin
          failures++;
          $display("FAIL bounce%0d_draw[%0d]: got plot=%0b x=%0d y=%0d col=%0d, want 1 %0d %0d 6",
                   p, k, cap_plot[17+k], cap_x[17+k], cap_y[17+k], cap_col[17+k], ex, ey);
        end
      end
      checks++;
      if (cap_busy[33] !== 1'b0) begin
        failures++;
        $display("FAIL bounce%0d_busy_end: got %0b, want 0", p, cap_busy[33]);
      end
    end
  endtask

  task automatic test_clamp;
    int ex, ey;
    do_reset();
    do_spawn(8'd200, 7'd127, 2'b00);
    capture(17, -1, -1, -1);
    for (int k = 0; k < 16; k++) begin
      ex = 156 + k % 4; ey = 116 + k / 4;
      checks++;
      if ({cap_plot[k], cap_x[k], cap_y[k]} !== {1'b1, 8'(ex), 7'(ey)}) begin
        failures++;
        $display("FAIL clamp_draw[%0d]: got plot=%0b x=%0d y=%0d, want 1 %0d %0d",
                 k, cap_plot[k], cap_x[k], cap_y[k], ex, ey);
      end
    end
  endtask

  task automatic test_tick_pend_overrun;
    int novr;
    do_reset();
    do_spawn(8'd50, 7'd40, 2'b00);
    capture(17, -1, -1, -1);
    do_tick();
    capture(68, 5, -1, -1);
    checks++;
    if ({cap_busy[32], cap_busy[33], cap_busy[66], cap_busy[67]} !== 4'b1010) begin
      failures++;
      $display("FAIL pend_busy: got b32=%0b b33=%0b b66=%0b b67=%0b, want 1 0 1 0",
               cap_busy[32], cap_busy[33], cap_busy[66], cap_busy[67]);
    end
    checks++;
    if ({cap_plot[34], cap_x[34], cap_y[34], cap_col[34]} !== {1'b1, 8'd51, 7'd41, 3'b000}) begin
      failures++;
      $display("FAIL pend_erase: got plot=%0b x=%0d y=%0d col=%0d, want 1 51 41 0",
               cap_plot[34], cap_x[34], cap_y[34], cap_col[34]);
    end
    checks++;
    if ({cap_plot[51], cap_x[51], cap_y[51], cap_col[51]} !== {1'b1, 8'd52, 7'd42, 3'b110}) begin
      failures++;
      $display("FAIL pend_draw: got plot=%0b x=%0d y=%0d col=%0d, want 1 52 42 6",
               cap_plot[51], cap_x[51], cap_y[51], cap_col[51]);
    end
    novr = 0;
    for (int i = 0; i < 68; i++) novr += int'(cap_ovr[i]);
    checks++;
    if (novr != 0) begin
      failures++;
      $display("FAIL pend_no_overrun: got %0d overrun cycles, want 0", novr);
    end
    do_tick();
    capture(70, 5, 9, -1);
    novr = 0;
    for (int i = 0; i < 70; i++) novr += int'(cap_ovr[i]);
    checks++;
    if ({cap_ovr[10], 32'(novr)} !== {1'b1, 32'd1}) begin
      failures++;
      $display("FAIL overrun_pulse: got ovr@10=%0b total=%0d, want 1 and 1", cap_ovr[10], novr);
    end
    checks++;
    if ({cap_plot[34], cap_x[34], cap_y[34], cap_busy[67], cap_busy[68]} !== {1'b1, 8'd53, 7'd43, 2'b00}) begin
      failures++;
      $display("FAIL overrun_service: got plot=%0b x=%0d y=%0d b67=%0b b68=%0b, want 1 53 43 0 0",
               cap_plot[34], cap_x[34], cap_y[34], cap_busy[67], cap_busy[68]);
    end
  endtask

  task automatic test_hit;
    int nplot;
    do_reset();
    do_spawn(8'd50, 7'd40, 2'b00);
    capture(17, -1, -1, -1);
    do_tick();
    capture(40, -1, -1, 3);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({cap_plot[i], cap_col[i], cap_alive[i]} !== {1'b1, 3'b000, 1'b1}) begin
        failures++;
        $display("FAIL hit_erase[%0d]: got plot=%0b col=%0d alive=%0b, want 1 0 1",
                 i, cap_plot[i], cap_col[i], cap_alive[i]);
      end
    end
    nplot = 0;
    for (int i = 16; i < 40; i++) nplot += int'(cap_plot[i]);
    checks++;
    if ({cap_alive[16], cap_busy[16], 32'(nplot)} !== {2'b00, 32'd0}) begin
      failures++;
      $display("FAIL hit_erase_end: got alive=%0b busy=%0b later_plots=%0d, want 0 0 0",
               cap_alive[16], cap_busy[16], nplot);
    end
    do_spawn(8'd50, 7'd40, 2'b00);
    capture(40, -1, -1, 4);
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (i == 16) begin
        if ({cap_plot[i], cap_alive[i]} !== 2'b01) begin
          failures++;
          $display("FAIL hit_draw_gap: got plot=%0b alive=%0b, want 0 1", cap_plot[i], cap_alive[i]);
        end
      end else if ({cap_plot[i], cap_x[i], cap_y[i], cap_col[i]} !==
                   {1'b1, 8'(50 + (i % 17) % 4), 7'(40 + (i % 17) / 4), (i < 16) ? 3'b110 : 3'b000}) begin
        failures++;
        $display("FAIL hit_draw_kill[%0d]: got plot=%0b x=%0d y=%0d col=%0d, want 1 %0d %0d %0d",
                 i, cap_plot[i], cap_x[i], cap_y[i], cap_col[i],
                 50 + (i % 17) % 4, 40 + (i % 17) / 4, (i < 16) ? 6 : 0);
      end
    end
    checks++;
    if ({cap_plot[33], cap_alive[33], cap_busy[33]} !== 3'b000) begin
      failures++;
      $display("FAIL hit_kill_end: got plot=%0b alive=%0b busy=%0b, want 0 0 0",
               cap_plot[33], cap_alive[33], cap_busy[33]);
    end
  endtask

  task automatic test_midpass_reset;
    int bad;
    do_reset();
    do_spawn(8'd50, 7'd40, 2'b00);
    repeat (5) @(negedge clock);
    checks++;
    if (plot !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre: got plot=%0b, want 1", plot);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({x_out, y_out, colour, plot, alive, busy, overrun} !== 22'd0) begin
      failures++;
      $display("FAIL midreset_async: got x=%0d y=%0d col=%0d plot=%0b alive=%0b busy=%0b, want all 0",
               x_out, y_out, colour, plot, alive, busy);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    do_tick();
    capture(20, -1, -1, -1);
    bad = 0;
    for (int i = 0; i < 20; i++) bad += int'(cap_plot[i] | cap_busy[i] | cap_alive[i]);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_tick_ignored: got %0d active cycles, want 0", bad);
    end
    do_spawn(8'd60, 7'd30, 2'b00);
    capture(17, -1, -1, -1);
    checks++;
    if ({cap_plot[0], cap_x[0], cap_y[0], cap_plot[15], cap_x[15], cap_y[15]} !==
        {1'b1, 8'd60, 7'd30, 1'b1, 8'd63, 7'd33}) begin
      failures++;
      $display("FAIL midreset_respawn: got first=(%0b,%0d,%0d) last=(%0b,%0d,%0d), want (1,60,30) (1,63,33)",
               cap_plot[0], cap_x[0], cap_y[0], cap_plot[15], cap_x[15], cap_y[15]);
    end
  endtask

  initial begin
    test_reset();
    test_spawn_tick();
    test_bounce();
    test_clamp();
    test_tick_pend_overrun();
    test_hit();
    test_midpass_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
